// File: rtl/order_book_levels_pkg.sv
// Shared message encodings, field widths and the price-level record used by
// both sides of the order book.
package order_book_pkg;

  localparam int PRICE_W    = 64;
  localparam int SYMBOL_W   = 48;
  localparam int OID_W      = 32;
  localparam int LVL_QTY_W  = 64;

  localparam logic MSG_ADD    = 1'b0;
  localparam logic MSG_CANCEL = 1'b1;
  localparam logic SIDE_BUY   = 1'b0;
  localparam logic SIDE_SELL  = 1'b1;

  typedef struct packed {
    logic [PRICE_W-1:0]   price;
    logic [LVL_QTY_W-1:0] qty;
  } level_t;

endpackage

// File: rtl/order_book_levels_book_side.sv
// One side of the book: a best-first sorted array of aggregated price levels,
// updated in a single cycle by parallel compare and a one-step shift.
module book_side
  import order_book_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit ASCENDING = 1'b0,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_type,
  input  logic [PRICE_W-1:0]   i_price,
  input  logic [LVL_QTY_W-1:0] i_qty,
  output level_t               o_top,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_update,
  output logic                 o_evict,
  output logic                 o_reject
);

  level_t             r_lvl_p1 [DEPTH];
  logic [CNT_W-1:0]   r_count_p1;
  logic               r_update_p1, r_evict_p1, r_reject_p1;

  level_t             w_nxt  [DEPTH];
  level_t             w_prev [DEPTH];
  level_t             w_succ [DEPTH];
  level_t             w_new;
  logic [DEPTH-1:0]   w_match, w_worse, w_prev_worse, w_rm_from;
  logic [CNT_W-1:0]   w_nxt_count;
  logic [IDX_W-1:0]   w_mi;
  logic               w_any_match, w_full, w_update, w_evict, w_reject;

  function automatic logic [LVL_QTY_W-1:0] add_sat(input logic [LVL_QTY_W-1:0] a,
                                                   input logic [LVL_QTY_W-1:0] b);
    logic [LVL_QTY_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[LVL_QTY_W] ? '1 : s[LVL_QTY_W-1:0];
  endfunction

  // "Worse" means further from the top of book for this side's sort order.
  function automatic logic is_worse(input logic [PRICE_W-1:0] lvl_p,
                                    input logic [PRICE_W-1:0] msg_p);
    return ASCENDING ? (lvl_p > msg_p) : (lvl_p < msg_p);
  endfunction

  assign w_any_match = |w_match;
  assign w_full      = (r_count_p1 == CNT_W'(DEPTH));
  assign w_new.price = i_price;
  assign w_new.qty   = i_qty;

  // w_worse is a thermometer (empty slots count as worse), so its first set
  // bit is the insert point and w_prev_worse marks the slots that shift down.
  always_comb begin : compare
    logic v_acc;
    logic v_occ;
    v_acc        = 1'b0;
    w_mi         = '0;
    w_match      = '0;
    w_worse      = '0;
    w_prev_worse = '0;
    w_rm_from    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_occ      = (CNT_W'(i) < r_count_p1);
      w_match[i] = v_occ && (r_lvl_p1[i].price == i_price);
      w_worse[i] = !v_occ || is_worse(r_lvl_p1[i].price, i_price);
      if (w_match[i]) w_mi = IDX_W'(i);
      v_acc        = v_acc | w_match[i];
      w_rm_from[i] = v_acc;
    end
    w_prev[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_prev[i]       = r_lvl_p1[i-1];
      w_prev_worse[i] = w_worse[i-1];
    end
    w_succ[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH - 1; i++) w_succ[i] = r_lvl_p1[i+1];
  end

  always_comb begin : next_state
    w_nxt       = r_lvl_p1;
    w_nxt_count = r_count_p1;
    w_update    = 1'b0;
    w_evict     = 1'b0;
    w_reject    = 1'b0;
    if (i_valid) begin
      if (i_type == MSG_ADD) begin
        if (i_qty == '0) begin
          w_reject = 1'b1;
        end else if (w_any_match) begin
          w_nxt[w_mi].qty = add_sat(r_lvl_p1[w_mi].qty, i_qty);
          w_update        = 1'b1;
        end else if (!(|w_worse)) begin
          w_reject = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++)
            w_nxt[i] = w_prev_worse[i] ? w_prev[i] : (w_worse[i] ? w_new : r_lvl_p1[i]);
          w_update = 1'b1;
          if (w_full) w_evict = 1'b1;
          else        w_nxt_count = r_count_p1 + CNT_W'(1);
        end
      end else begin
        if (!w_any_match) begin
          w_reject = 1'b1;
        end else if (i_qty >= r_lvl_p1[w_mi].qty) begin
          for (int i = 0; i < DEPTH; i++)
            w_nxt[i] = w_rm_from[i] ? w_succ[i] : r_lvl_p1[i];
          w_nxt_count = r_count_p1 - CNT_W'(1);
          w_update    = 1'b1;
        end else begin
          w_nxt[w_mi].qty = r_lvl_p1[w_mi].qty - i_qty;
          w_update        = 1'b1;
        end
      end
    end
  end

  // ---- stage p1: book state and result pulses ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_lvl_p1[i] <= '0;
      r_count_p1  <= '0;
      r_update_p1 <= 1'b0;
      r_evict_p1  <= 1'b0;
      r_reject_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_lvl_p1[i] <= w_nxt[i];
      r_count_p1  <= w_nxt_count;
      r_update_p1 <= w_update;
      r_evict_p1  <= w_evict;
      r_reject_p1 <= w_reject;
    end
  end

  assign o_top    = r_lvl_p1[0];
  assign o_count  = r_count_p1;
  assign o_update = r_update_p1;
  assign o_evict  = r_evict_p1;
  assign o_reject = r_reject_p1;

endmodule

// File: rtl/order_book_levels.sv
// Single-instrument price-level order book: filters on symbol, routes each
// message to the bid or ask side and publishes top-of-book every cycle.
module order_book_levels
  import order_book_pkg::*;
#(
  parameter int                  DEPTH  = 8,
  parameter logic [SYMBOL_W-1:0] SYMBOL = 48'h0,
  parameter int                  QTY_W  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                msg_valid,
  input  logic                msg_type,
  input  logic [SYMBOL_W-1:0] symbol_id,
  input  logic                side,
  input  logic [PRICE_W-1:0]  price,
  input  logic [QTY_W-1:0]    quantity,
  input  logic [OID_W-1:0]    order_id,
  output logic                book_update,
  output logic                reject,
  output logic                evict,
  output logic [OID_W-1:0]    last_order_id,
  output logic                best_bid_valid,
  output logic [PRICE_W-1:0]  best_bid_price,
  output logic [QTY_W-1:0]    best_bid_qty,
  output logic                best_ask_valid,
  output logic [PRICE_W-1:0]  best_ask_price,
  output logic [QTY_W-1:0]    best_ask_qty
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             w_accept, w_bid_vld, w_ask_vld;
  level_t           w_bid_top, w_ask_top;
  logic [CNT_W-1:0] w_bid_count, w_ask_count;
  logic             w_bid_upd, w_bid_evict, w_bid_rej;
  logic             w_ask_upd, w_ask_evict, w_ask_rej;
  logic [OID_W-1:0] r_last_oid_p1;

  assign w_accept  = msg_valid && (symbol_id == SYMBOL);
  assign w_bid_vld = w_accept && (side == SIDE_BUY);
  assign w_ask_vld = w_accept && (side == SIDE_SELL);

  book_side #(.DEPTH(DEPTH), .ASCENDING(1'b0)) u_bid (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_bid_vld),
    .i_type   (msg_type),
    .i_price  (price),
    .i_qty    (quantity),
    .o_top    (w_bid_top),
    .o_count  (w_bid_count),
    .o_update (w_bid_upd),
    .o_evict  (w_bid_evict),
    .o_reject (w_bid_rej)
  );

  book_side #(.DEPTH(DEPTH), .ASCENDING(1'b1)) u_ask (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_ask_vld),
    .i_type   (msg_type),
    .i_price  (price),
    .i_qty    (quantity),
    .o_top    (w_ask_top),
    .o_count  (w_ask_count),
    .o_update (w_ask_upd),
    .o_evict  (w_ask_evict),
    .o_reject (w_ask_rej)
  );

  // ---- stage p1: order id of the last accepted message ----
  always_ff @(posedge clk) begin
    if (rst) r_last_oid_p1 <= '0;
    else if (w_accept) r_last_oid_p1 <= order_id;
  end

  assign last_order_id  = r_last_oid_p1;
  assign book_update    = w_bid_upd | w_ask_upd;
  assign reject         = w_bid_rej | w_ask_rej;
  assign evict          = w_bid_evict | w_ask_evict;

  assign best_bid_valid = (w_bid_count != '0);
  assign best_bid_price = best_bid_valid ? w_bid_top.price : '0;
  assign best_bid_qty   = best_bid_valid ? w_bid_top.qty   : '0;
  assign best_ask_valid = (w_ask_count != '0);
  assign best_ask_price = best_ask_valid ? w_ask_top.price : '0;
  assign best_ask_qty   = best_ask_valid ? w_ask_top.qty   : '0;

endmodule

// File: tb/tb_order_book_levels.sv
// Directed-vector bench for order_book_levels with hand-computed expectations.
module tb_order_book_levels;

  localparam logic [47:0] SYM = 48'h0000_1234_5678;
  localparam logic [47:0] BAD = 48'h0000_1234_5679;
  localparam logic ADD = 1'b0, CAN = 1'b1, BUY = 1'b0, SELL = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        msg_valid = 1'b0, msg_type = 1'b0, side = 1'b0;
  logic [47:0] symbol_id = '0;
  logic [63:0] price = '0, quantity = '0;
  logic [31:0] order_id = '0;
  logic        book_update, reject, evict;
  logic [31:0] last_order_id;
  logic        best_bid_valid, best_ask_valid;
  logic [63:0] best_bid_price, best_bid_qty, best_ask_price, best_ask_qty;

  int n_checks = 0;
  int n_fail   = 0;

  order_book_levels #(.DEPTH(8), .SYMBOL(SYM), .QTY_W(64)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_type(msg_type),
    .symbol_id(symbol_id), .side(side), .price(price), .quantity(quantity),
    .order_id(order_id), .book_update(book_update), .reject(reject), .evict(evict),
    .last_order_id(last_order_id), .best_bid_valid(best_bid_valid),
    .best_bid_price(best_bid_price), .best_bid_qty(best_bid_qty),
    .best_ask_valid(best_ask_valid), .best_ask_price(best_ask_price),
    .best_ask_qty(best_ask_qty)
  );

  always #5 clk = ~clk;

  // Present one message for exactly one cycle; returns 1ns after the edge that consumed it.
  task automatic send(input logic t, input logic s, input logic [63:0] p, input logic [63:0] q,
                      input logic [31:0] oid, input logic [47:0] sym);
    @(negedge clk);
    msg_valid = 1'b1; msg_type = t; side = s; price = p; quantity = q;
    order_id = oid; symbol_id = sym;
    @(posedge clk); #1;
    msg_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; msg_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (best_bid_valid !== 1'b0) begin $display("FAIL rst_bid_valid got %0d want 0", best_bid_valid); n_fail++; end n_checks++;
    if (best_ask_valid !== 1'b0) begin $display("FAIL rst_ask_valid got %0d want 0", best_ask_valid); n_fail++; end n_checks++;
    if (best_bid_price !== 64'd0 || best_bid_qty !== 64'd0) begin $display("FAIL rst_bid got %0d/%0d want 0/0", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    if (best_ask_price !== 64'd0 || best_ask_qty !== 64'd0) begin $display("FAIL rst_ask got %0d/%0d want 0/0", best_ask_price, best_ask_qty); n_fail++; end n_checks++;
    if ({book_update, reject, evict} !== 3'b000) begin $display("FAIL rst_pulses got %b want 000", {book_update, reject, evict}); n_fail++; end n_checks++;
    if (last_order_id !== 32'd0) begin $display("FAIL rst_oid got %0d want 0", last_order_id); n_fail++; end n_checks++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_bid_order();
    send(ADD, BUY, 64'd100, 64'd10, 32'd1, SYM);
    if (book_update !== 1'b1) begin $display("FAIL bid1_upd got %0d want 1", book_update); n_fail++; end n_checks++;
    if (best_bid_price !== 64'd100 || best_bid_qty !== 64'd10) begin $display("FAIL bid1_best got %0d/%0d want 100/10", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    send(ADD, BUY, 64'd102, 64'd5, 32'd2, SYM);
    if (best_bid_price !== 64'd102 || best_bid_qty !== 64'd5) begin $display("FAIL bid2_best got %0d/%0d want 102/5", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    send(ADD, BUY, 64'd101, 64'd7, 32'd3, SYM);
    if (book_update !== 1'b1 || reject !== 1'b0) begin $display("FAIL bid3_pulses got upd=%0d rej=%0d want 1/0", book_update, reject); n_fail++; end n_checks++;
    if (best_bid_price !== 64'd102 || best_bid_qty !== 64'd5) begin $display("FAIL bid3_best got %0d/%0d want 102/5", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    if (last_order_id !== 32'd3) begin $display("FAIL bid3_oid got %0d want 3", last_order_id); n_fail++; end n_checks++;
    if (best_ask_valid !== 1'b0) begin $display("FAIL bid3_ask_empty got %0d want 0", best_ask_valid); n_fail++; end n_checks++;
    // Peel the levels off the top to confirm the stored order 102,101,100.
    send(CAN, BUY, 64'd102, 64'd5, 32'd4, SYM);
    if (best_bid_price !== 64'd101 || best_bid_qty !== 64'd7) begin $display("FAIL peel1 got %0d/%0d want 101/7", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    send(CAN, BUY, 64'd101, 64'd7, 32'd5, SYM);
    if (best_bid_price !== 64'd100 || best_bid_qty !== 64'd10) begin $display("FAIL peel2 got %0d/%0d want 100/10", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    send(CAN, BUY, 64'd100, 64'd10, 32'd6, SYM);
    if (best_bid_valid !== 1'b0 || best_bid_price !== 64'd0 || best_bid_qty !== 64'd0) begin $display("FAIL peel3 got v=%0d %0d/%0d want 0 0/0", best_bid_valid, best_bid_price, best_bid_qty); n_fail++; end n_checks++;
  endtask

  task automatic test_ask_merge();
    send(ADD, SELL, 64'd200, 64'd4, 32'd7, SYM);
    if (best_ask_valid !== 1'b1 || best_ask_price !== 64'd200 || best_ask_qty !== 64'd4) begin $display("FAIL ask1 got v=%0d %0d/%0d want 1 200/4", best_ask_valid, best_ask_price, best_ask_qty); n_fail++; end n_checks++;
    send(ADD, SELL, 64'd200, 64'd6, 32'd8, SYM);
    if (book_update !== 1'b1) begin $display("FAIL ask2_upd got %0d want 1", book_update); n_fail++; end n_checks++;
    if (best_ask_price !== 64'd200 || best_ask_qty !== 64'd10) begin $display("FAIL ask2_best got %0d/%0d want 200/10", best_ask_price, best_ask_qty); n_fail++; end n_checks++;
    send(CAN, SELL, 64'd200, 64'd10, 32'd9, SYM);
    if (best_ask_valid !== 1'b0) begin $display("FAIL ask_count1 got valid=%0d want 0", best_ask_valid); n_fail++; end n_checks++;
  endtask

  task automatic test_full_evict();
    do_reset();
    for (int k = 1; k <= 8; k++) send(ADD, BUY, 64'(100 + k), 64'(k), 32'(20 + k), SYM);
    if (best_bid_price !== 64'd108 || best_bid_qty !== 64'd8) begin $display("FAIL full_best got %0d/%0d want 108/8", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    if (evict !== 1'b0) begin $display("FAIL full_no_evict got %0d want 0", evict); n_fail++; end n_checks++;
    send(ADD, BUY, 64'd100, 64'd9, 32'd50, SYM);
    if (reject !== 1'b1 || book_update !== 1'b0 || evict !== 1'b0) begin $display("FAIL worse_rej got rej=%0d upd=%0d ev=%0d want 1/0/0", reject, book_update, evict); n_fail++; end n_checks++;
    if (best_bid_price !== 64'd108 || last_order_id !== 32'd50) begin $display("FAIL worse_state got %0d oid=%0d want 108 oid=50", best_bid_price, last_order_id); n_fail++; end n_checks++;
    send(ADD, BUY, 64'd109, 64'd9, 32'd51, SYM);
    if (book_update !== 1'b1 || evict !== 1'b1) begin $display("FAIL evict_pulse got upd=%0d ev=%0d want 1/1", book_update, evict); n_fail++; end n_checks++;
    if (best_bid_price !== 64'd109 || best_bid_qty !== 64'd9) begin $display("FAIL evict_best got %0d/%0d want 109/9", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    send(CAN, BUY, 64'd101, 64'd1, 32'd52, SYM);
    if (reject !== 1'b1 || book_update !== 1'b0) begin $display("FAIL evicted_gone got rej=%0d upd=%0d want 1/0", reject, book_update); n_fail++; end n_checks++;
    send(CAN, BUY, 64'd102, 64'd2, 32'd53, SYM);
    if (reject !== 1'b0 || book_update !== 1'b1) begin $display("FAIL kept_102 got rej=%0d upd=%0d want 0/1", reject, book_update); n_fail++; end n_checks++;
  endtask

  task automatic test_cancel();
    do_reset();
    send(ADD, BUY, 64'd102, 64'd5, 32'd60, SYM);
    send(ADD, BUY, 64'd101, 64'd7, 32'd61, SYM);
    send(CAN, BUY, 64'd102, 64'd3, 32'd62, SYM);
    if (book_update !== 1'b1 || best_bid_price !== 64'd102 || best_bid_qty !== 64'd2) begin $display("FAIL can_partial got upd=%0d %0d/%0d want 1 102/2", book_update, best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    send(CAN, BUY, 64'd102, 64'd9, 32'd63, SYM);
    if (best_bid_price !== 64'd101 || best_bid_qty !== 64'd7) begin $display("FAIL can_remove got %0d/%0d want 101/7", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    send(CAN, BUY, 64'd150, 64'd1, 32'd64, SYM);
    if (reject !== 1'b1 || book_update !== 1'b0) begin $display("FAIL can_nomatch got rej=%0d upd=%0d want 1/0", reject, book_update); n_fail++; end n_checks++;
    if (best_bid_price !== 64'd101 || best_bid_qty !== 64'd7) begin $display("FAIL can_nomatch_state got %0d/%0d want 101/7", best_bid_price, best_bid_qty); n_fail++; end n_checks++;
    send(CAN, SELL, 64'd300, 64'd1, 32'd65, SYM);
    if (reject !== 1'b1 || last_order_id !== 32'd65) begin $display("FAIL can_empty got rej=%0d oid=%0d want 1 oid=65", reject, last_order_id); n_fail++; end n_checks++;
    send(ADD, BUY, 64'd105, 64'd0, 32'd66, SYM);
    if (reject !== 1'b1 || best_bid_price !== 64'd101) begin $display("FAIL add_zero got rej=%0d best=%0d want 1 101", reject, best_bid_price); n_fail++; end n_checks++;
  endtask

  task automatic test_saturation();
    send(ADD, BUY, 64'd101, 64'hFFFF_FFFF_FFFF_FFF0, 32'd70, SYM);
    if (best_bid_qty !== 64'hFFFF_FFFF_FFFF_FFF7) begin $display("FAIL sat_nowrap got %h want fffffffffffffff7", best_bid_qty); n_fail++; end n_checks++;
    send(ADD, BUY, 64'd101, 64'd100, 32'd71, SYM);
    if (best_bid_qty !== 64'hFFFF_FFFF_FFFF_FFFF) begin $display("FAIL sat_clip got %h want ffffffffffffffff", best_bid_qty); n_fail++; end n_checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        send(ADD, SELL, 64'(500 + k), 64'd1, 32'(10 + k), SYM);
        if (book_update !== 1'b1 || best_ask_price !== 64'd500 || last_order_id !== 32'(10 + k)) begin
          $display("FAIL b2b_good%0d got upd=%0d best=%0d oid=%0d want 1 500 %0d", k, book_update, best_ask_price, last_order_id, 10 + k); n_fail++;
        end
        n_checks++;
      end else begin
        send(ADD, SELL, 64'd400, (k == 3) ? 64'd0 : 64'd1, 32'd99, BAD);
        if ({book_update, reject, evict} !== 3'b000 || best_ask_price !== 64'd500 || best_ask_qty !== 64'd1 || last_order_id !== 32'(9 + k)) begin
          $display("FAIL b2b_bad%0d got pulses=%b best=%0d/%0d oid=%0d want 000 500/1 %0d", k, {book_update, reject, evict}, best_ask_price, best_ask_qty, last_order_id, 9 + k); n_fail++;
        end
        n_checks++;
      end
    end
  endtask

  task automatic test_reset_collision();
    @(negedge clk);
    rst = 1'b1; msg_valid = 1'b1; msg_type = ADD; side = BUY;
    price = 64'd700; quantity = 64'd1; order_id = 32'd77; symbol_id = SYM;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    if (best_ask_valid !== 1'b0 || best_bid_valid !== 1'b0 || best_ask_price !== 64'd0 || best_bid_price !== 64'd0) begin $display("FAIL coll_book got bv=%0d av=%0d bp=%0d ap=%0d want 0 0 0 0", best_bid_valid, best_ask_valid, best_bid_price, best_ask_price); n_fail++; end n_checks++;
    if ({book_update, reject, evict} !== 3'b000 || last_order_id !== 32'd0) begin $display("FAIL coll_out got pulses=%b oid=%0d want 000 0", {book_update, reject, evict}, last_order_id); n_fail++; end n_checks++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    if (best_bid_valid !== 1'b0 || best_bid_qty !== 64'd0) begin $display("FAIL coll_lost got v=%0d qty=%0d want 0 0", best_bid_valid, best_bid_qty); n_fail++; end n_checks++;
  endtask

  initial begin
    test_reset();
    test_bid_order();
    test_ask_merge();
    test_full_evict();
    test_cancel();
    test_saturation();
    test_back_to_back();
    test_reset_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
